// File: rtl/prep_scheduler.sv
// Sequences dirty shapes through the shared trig/rotate unit once per vblank.
// One pass issues load, waits LAT cycles, then commits, per pending shape.
module prep_scheduler #(
    parameter int MAXSHP = 16,
    parameter int IDW    = 4,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              endframe,
    input  logic [MAXSHP-1:0] dirty_set,
    input  logic              force_all,
    input  logic              hold,
    output logic              ld_en,
    output logic [IDW-1:0]    ld_id,
    output logic              wr_en,
    output logic [IDW-1:0]    wr_id,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_COMMIT,
        S_FINISH
    } state_t;

    localparam logic [3:0]        LAST_WAIT = 4'(LAT - 1);
    localparam logic [MAXSHP-1:0] ONE       = {{(MAXSHP-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [MAXSHP-1:0] r_pending;
    logic [MAXSHP-1:0] r_active;
    logic [3:0]        r_cnt;

    logic [MAXSHP-1:0] w_fresh;
    logic [MAXSHP-1:0] w_snap;
    logic              w_start;

    function automatic logic [IDW-1:0] f_lowest(input logic [MAXSHP-1:0] m);
        f_lowest = '0;
        for (int i = MAXSHP - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = IDW'(i);
        end
    endfunction

    // Clears the lowest set bit, i.e. the shape just handed to the unit.
    function automatic logic [MAXSHP-1:0] f_drop(input logic [MAXSHP-1:0] m);
        f_drop = m & (m - ONE);
    endfunction

    assign w_fresh = dirty_set | (force_all ? {MAXSHP{1'b1}} : {MAXSHP{1'b0}});
    assign w_snap  = r_pending | dirty_set;
    assign w_start = endframe & ~hold & (|w_snap);
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '1;
            r_active  <= '0;
            r_cnt     <= '0;
            ld_en     <= 1'b0;
            ld_id     <= '0;
            wr_en     <= 1'b0;
            wr_id     <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ld_en     <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            r_pending <= r_pending | w_fresh;
            if (endframe && r_state != S_IDLE) overrun <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_LOAD;
                        ld_en     <= 1'b1;
                        ld_id     <= f_lowest(w_snap);
                        r_active  <= f_drop(w_snap);
                        r_pending <= w_fresh;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (r_cnt == LAST_WAIT) begin
                        r_state <= S_COMMIT;
                        r_cnt   <= '0;
                        wr_en   <= 1'b1;
                        wr_id   <= ld_id;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_COMMIT: begin
                    if (|r_active) begin
                        r_state  <= S_LOAD;
                        ld_en    <= 1'b1;
                        ld_id    <= f_lowest(r_active);
                        r_active <= f_drop(r_active);
                    end else begin
                        r_state <= S_FINISH;
                        done    <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prep_scheduler.sv
// Scoreboard bench for prep_scheduler: expected ld/wr/done events are
// queued with their cycle stamps when a pass is triggered.
module tb_prep_scheduler;

    localparam int MAXSHP = 16;
    localparam int IDW    = 4;
    localparam int LAT    = 4;
    localparam int STEP   = LAT + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              endframe;
    logic [MAXSHP-1:0] dirty_set;
    logic              force_all;
    logic              hold;
    logic              ld_en;
    logic [IDW-1:0]    ld_id;
    logic              wr_en;
    logic [IDW-1:0]    wr_id;
    logic              busy;
    logic              done;
    logic              overrun;

    typedef struct {
        int kind;
        int id;
        int cyc;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  n_vec  = 0;
    int  n_err  = 0;

    prep_scheduler #(
        .MAXSHP(MAXSHP),
        .IDW   (IDW),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .endframe (endframe),
        .dirty_set(dirty_set),
        .force_all(force_all),
        .hold     (hold),
        .ld_en    (ld_en),
        .ld_id    (ld_id),
        .wr_en    (wr_en),
        .wr_id    (wr_id),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int id, input int c);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // kind 0 = load, 1 = commit, 2 = done
    task automatic push_pass(input logic [MAXSHP-1:0] mask, input int e);
        int k = 0;
        for (int i = 0; i < MAXSHP; i++) begin
            if (mask[i]) begin
                push_ev(0, i, e + k * STEP);
                push_ev(1, i, e + k * STEP + LAT + 1);
                k++;
            end
        end
        push_ev(2, 0, e + k * STEP);
    endtask

    // Called at a negedge; the pulse is sampled by the next rising edge.
    task automatic fire(input logic [MAXSHP-1:0] mask, input bit runs, output int e);
        endframe = 1'b1;
        e = cyc + 1;
        if (runs) push_pass(mask, e);
        @(negedge clk);
        endframe = 1'b0;
    endtask

    task automatic pulse_dirty(input logic [MAXSHP-1:0] m);
        dirty_set = m;
        @(negedge clk);
        dirty_set = '0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic settle(input int n, input string tag);
        repeat (n) @(negedge clk);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ld_en"}, int'(ld_en), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_ld_id"}, int'(ld_id), 0);
        chk({tag, "_wr_id"}, int'(wr_id), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (ld_en === 1'b1 || wr_en === 1'b1 || done === 1'b1)) begin
            int kind;
            int id;
            ev_t e;
            chk("ld_wr_excl", int'(ld_en & wr_en), 0);
            kind = ld_en ? 0 : (wr_en ? 1 : 2);
            id   = ld_en ? int'(ld_id) : (wr_en ? int'(wr_id) : 0);
            chk("ev_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ev_kind", kind, e.kind);
                chk("ev_id", id, e.id);
                chk("ev_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst       = 1'b1;
        endframe  = 1'b0;
        dirty_set = '0;
        force_all = 1'b0;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full pass straight out of reset.
        fire('1, 1'b1, e);
        settle(110, "full");

        // Two dirty shapes, then an endframe with nothing pending.
        pulse_dirty(16'h0024);
        fire(16'h0024, 1'b1, e);
        settle(20, "pair");
        fire('0, 1'b0, e);
        settle(20, "empty");

        // Shape 2 re-dirtied while shape 5 waits.
        pulse_dirty(16'h0024);
        fire(16'h0024, 1'b1, e);
        wait_until(e + 7);
        pulse_dirty(16'h0004);
        settle(20, "redirty");
        fire(16'h0004, 1'b1, e);
        settle(15, "redirty2");

        // endframe mid-pass flags overrun and leaves the pass intact.
        chk("overrun_pre", int'(overrun), 0);
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
        fire('1, 1'b1, e);
        wait_until(e + 30);
        fire('0, 1'b0, e);
        chk("overrun_set", int'(overrun), 1);
        settle(110, "overrun");
        chk("overrun_sticky", int'(overrun), 1);

        // hold blocks a pass start.
        pulse_dirty(16'h0001);
        hold = 1'b1;
        fire(16'h0001, 1'b0, e);
        settle(10, "hold");
        hold = 1'b0;
        fire(16'h0001, 1'b1, e);
        settle(15, "unhold");

        // Reset while shape 3 waits: no commit for it, restart from 0.
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
        endframe = 1'b1;
        e = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            push_ev(0, i, e + i * STEP);
            push_ev(1, i, e + i * STEP + LAT + 1);
        end
        push_ev(0, 3, e + 3 * STEP);
        @(negedge clk);
        endframe = 1'b0;
        wait_until(e + 3 * STEP + 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("midrst");
        chk("midrst_drain", sb.size(), 0);
        settle(10, "midrst_quiet");
        fire('1, 1'b1, e);
        settle(110, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
